// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer sequencer: FSM encoding, weight word
// count and the conv weight-map offsets that follow the kernel block.
package conv_pkg;

  localparam int WORD_W      = 16;
  localparam int CONV_ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_DONE
  } seq_state_e;

  function automatic int weight_words(input int k0, input int k1, input int ic, input int oc);
    return k0 * k1 * ic * oc + oc + 2;
  endfunction

  // Weight map inside the conv: kernel, then one bias per output channel,
  // then the MACC coefficient, then the layer scale.
  function automatic int bias_offset(input int k0, input int k1, input int ic, input int oc);
    return k0 * k1 * ic * oc;
  endfunction

  function automatic int macc_offset(input int k0, input int k1, input int ic, input int oc);
    return bias_offset(k0, k1, ic, oc) + oc;
  endfunction

  function automatic int scale_offset(input int k0, input int k1, input int ic, input int oc);
    return macc_offset(k0, k1, ic, oc) + 1;
  endfunction

endpackage

// File: rtl/conv_seq_wload.sv
// Weight loader: read-issue counter, one-cycle write stage into the conv and
// the optional running checksum (enabled by CONV_SEQ_CHECKSUM_EN).
module conv_seq_wload
  import conv_pkg::*;
#(
  parameter int N_WORDS    = 40,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 0,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   issue,
  output logic                   last_issue,
  output logic                   mem_rd_en,
  output logic [MEM_ADDR_W-1:0]  mem_rd_addr,
  input  logic [WORD_W-1:0]      mem_rd_data,
  output logic                   weight_wr_en,
  output logic [CONV_ADDR_W-1:0] weight_wr_addr,
  output logic [WORD_W-1:0]      weight_wr_data,
  output logic                   sum_ok
);

`ifdef CONV_SEQ_CHECKSUM_EN
  localparam int N_READS = N_WORDS + 1;
`else
  localparam int N_READS = N_WORDS;
`endif
  localparam int K_W = $clog2(N_READS + 1);

  logic [K_W-1:0]         rd_idx;
  logic                   wr_en_q;
  logic [CONV_ADDR_W-1:0] wr_addr_q;

  // NOTE: reset is synchronous (sampled on the clock edge); sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (rst || clear) rd_idx <= '0;
    else if (issue)   rd_idx <= rd_idx + 1'b1;
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? MEM_ADDR_W'(SRC_BASE) + MEM_ADDR_W'(rd_idx) : '0;
  assign last_issue  = issue && (rd_idx == K_W'(N_READS - 1));

  // Write k lines up with read data k, one cycle after its read strobe; the
  // trailing checksum word is read but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= issue && (rd_idx < K_W'(N_WORDS));
      if (issue) wr_addr_q <= CONV_ADDR_W'(DST_BASE) + CONV_ADDR_W'(rd_idx);
    end
  end

  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_en_q ? mem_rd_data : '0;

`ifdef CONV_SEQ_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || clear) sum_q <= '0;
    else if (wr_en_q) sum_q <= sum_q + mem_rd_data;
  end

  // Valid in DRAIN, where the expected sum is on the read data bus.
  assign sum_ok = (sum_q == mem_rd_data);
`else
  assign sum_ok = 1'b1;
`endif

endmodule

// File: rtl/conv_layer_seq.sv
// Per-layer sequencer: loads conv weights, admits one frame, counts outputs,
// pulses done. Optional weight checksum via CONV_SEQ_CHECKSUM_EN.
module conv_layer_seq
  import conv_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int IN_HEIGHT   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_HEIGHT  = 8,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3,
  parameter int IN_CHANNEL  = 2,
  parameter int OUT_CHANNEL = 2,
  parameter int SRC_BASE    = 0,
  parameter int DST_BASE    = 0,
  parameter int MEM_ADDR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [15:0]           mem_rd_data,
  output logic                  weight_wr_en,
  output logic [31:0]           weight_wr_addr,
  output logic [15:0]           weight_wr_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  conv_i_valid,
  input  logic                  conv_o_valid,
  output logic [15:0]           out_count
);

  localparam int N_WORDS   = weight_words(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
  localparam int FRAME_PIX = IN_WIDTH * IN_HEIGHT;
  localparam int FRAME_OUT = OUT_WIDTH * OUT_HEIGHT;
  localparam int IN_CNT_W  = $clog2(FRAME_PIX + 1);
  localparam int OUT_CNT_W = $clog2(FRAME_OUT + 1);

  seq_state_e           state, state_nxt;
  logic [IN_CNT_W-1:0]  in_cnt;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic                 clear, last_issue, err_set;
`ifdef CONV_SEQ_CHECKSUM_EN
  logic                 sum_ok;
`else
  logic                 sum_ok_unused;
`endif

  conv_seq_wload #(
    .N_WORDS    (N_WORDS),
    .SRC_BASE   (SRC_BASE),
    .DST_BASE   (DST_BASE),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_wload (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .issue          (state == S_LOAD),
    .last_issue     (last_issue),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .weight_wr_en   (weight_wr_en),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_data (weight_wr_data),
`ifdef CONV_SEQ_CHECKSUM_EN
    .sum_ok         (sum_ok)
`else
    .sum_ok         (sum_ok_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_LOAD;
        clear     = 1'b1;
      end
      S_LOAD:  if (last_issue) state_nxt = S_DRAIN;
`ifdef CONV_SEQ_CHECKSUM_EN
      S_DRAIN: if (sum_ok) state_nxt = S_RUN;
               else begin
                 state_nxt = S_DONE;
                 err_set   = 1'b1;
               end
`else
      S_DRAIN: state_nxt = S_RUN;
`endif
      S_RUN:   if (conv_o_valid && out_cnt == OUT_CNT_W'(FRAME_OUT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign s_ready      = (state == S_RUN) && (in_cnt != IN_CNT_W'(FRAME_PIX));
  assign conv_i_valid = s_valid && s_ready;
  assign out_count    = 16'(out_cnt);

  // Output beats only count in RUN; the count holds until the next start.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (conv_i_valid) in_cnt <= in_cnt + 1'b1;
      if (state == S_RUN && conv_o_valid && out_cnt != OUT_CNT_W'(FRAME_OUT))
        out_cnt <= out_cnt + 1'b1;
    end
  end

`ifdef CONV_SEQ_CHECKSUM_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || clear) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: weight load timing, frame gating, output
// counting, ignored starts, mid-load reset and (CONV_SEQ_CHECKSUM_EN) checksum.
`timescale 1ns/1ps
module tb_conv_layer_seq;

  localparam int N = 40;
`ifdef CONV_SEQ_CHECKSUM_EN
  localparam int NR     = N + 1;
  localparam int RUN_AT = N + 3;
`else
  localparam int NR     = N;
  localparam int RUN_AT = N + 2;
`endif

  logic        clk = 1'b0;
  logic        rst, start, s_valid, conv_o_valid;
  logic        busy, done, err, mem_rd_en, weight_wr_en, s_ready, conv_i_valid;
  logic [15:0] mem_rd_addr, mem_rd_data, weight_wr_data, out_count;
  logic [31:0] weight_wr_addr;
  logic [15:0] mem [0:63];
  int          total = 0;
  int          bad   = 0;

  conv_layer_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .weight_wr_en   (weight_wr_en),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_data (weight_wr_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .conv_i_valid   (conv_i_valid),
    .conv_o_valid   (conv_o_valid),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[5:0]];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, done, err, mem_rd_en, mem_rd_addr, weight_wr_en, weight_wr_addr,
                weight_wr_data, s_ready, conv_i_valid, out_count}, '0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  // Checks cycles T+1..T+last_c after the start edge T; start is held into
  // LOAD and a stray conv_o_valid is pulsed there, both must be ignored.
  task automatic watch_load(input int last_c);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      conv_o_valid = (c == 5 || c == 6);
      check("busy_load", busy, 1'b1);
      check("rd_en", mem_rd_en, (c <= NR));
      if (c <= NR) check("rd_addr", mem_rd_addr, c - 1);
      check("wr_en", weight_wr_en, (c >= 2 && c <= N + 1));
      if (c >= 2 && c <= N + 1) begin
        check("wr_addr", weight_wr_addr, c - 2);
        check("wr_data", weight_wr_data, mem[c-2]);
      end
      check("s_ready_load", s_ready, (c >= RUN_AT));
      if (c == 8) check("out_count_load", out_count, 16'd0);
    end
    conv_o_valid = 1'b0;
  endtask

  initial begin
    int          acc;
    int          dcount;
    logic [15:0] sum;

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; conv_o_valid = 1'b0;
    sum = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    for (int i = 0; i < N; i++) begin
      mem[i] = 16'(16'h1357 + i * 16'h0321);
      sum    = sum + mem[i];
    end
    mem[N] = sum;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    // Full layer: load, frame with 10 extra pixels, 64 output beats.
    do_start();
    watch_load(RUN_AT);
    s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 74; i++) begin
      #1;
      if (conv_i_valid) acc++;
      @(negedge clk);
    end
    check("pixels_accepted", acc, 64);
    check("s_ready_after_frame", s_ready, 1'b0);
    s_valid = 1'b0;

    dcount = 0;
    for (int b = 0; b < 64; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (done) dcount++;
      end
      conv_o_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      conv_o_valid = 1'b0;
      if (b < 63 && done) dcount++;
    end
    check("early_done", dcount, 0);
    check("done_after_last_beat", done, 1'b1);
    check("busy_in_done", busy, 1'b1);
    check("out_count_full", out_count, 16'd64);
    check("err_normal", err, 1'b0);
    start = 1'b1;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_fell", busy, 1'b0);
    start = 1'b0;
    conv_o_valid = 1'b1;
    @(negedge clk);
    conv_o_valid = 1'b0;
    check("start_in_done_ignored", {busy, mem_rd_en}, 2'b00);
    check("out_count_idle_hold", out_count, 16'd64);

    // Reset at write 20, then a fresh load from word 0.
    do_start();
    watch_load(22);
    check("at_write_20", weight_wr_addr, 32'd20);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_load");
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_done_after_reset", dcount, 0);
    do_start();
    watch_load(RUN_AT);

`ifdef CONV_SEQ_CHECKSUM_EN
    // Corrupted checksum: done with err at T+N+3, RUN skipped.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem[N] = sum ^ 16'h0001;
    do_start();
    watch_load(N + 2);
    @(negedge clk);
    check("bad_sum_done", done, 1'b1);
    check("bad_sum_err", err, 1'b1);
    check("bad_sum_no_ready", s_ready, 1'b0);
    @(negedge clk);
    check("bad_sum_idle", {busy, done, s_ready}, 3'b000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
